// File: rtl/l2_tcdm_bist_pkg.sv
// Types, constants and the pattern generator shared by the L2 TCDM BIST master.
//   state_e      : controller states
//   mode_e       : test mode selected at start
//   pattern_e    : data pattern selected at start
//   BE_ALL       : full-word byte enable
//   pattern_data : expected/write data for a given byte address
package l2_tcdm_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WR_DRAIN,
        ST_READ,
        ST_RD_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_WR_CHK   = 2'd0,
        MODE_WR_ONLY  = 2'd1,
        MODE_CHK_ONLY = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        PAT_ZERO  = 2'd0,
        PAT_ONES  = 2'd1,
        PAT_ADDR  = 2'd2,
        PAT_NADDR = 2'd3
    } pattern_e;

    localparam logic [3:0] BE_ALL = 4'hF;

    function automatic logic [31:0] pattern_data(input pattern_e pat, input logic [31:0] addr);
        logic [31:0] data;
        case (pat)
            PAT_ZERO:  data = '0;
            PAT_ONES:  data = '1;
            PAT_ADDR:  data = addr;
            PAT_NADDR: data = ~addr;
            default:   data = '0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/l2_tcdm_bist_master.sv
// TCDM initiator running a write-then-read-back memory test over a programmable
// address range, counting data mismatches and response errors.
//   clk_i/rst_ni          : clock, asynchronous active-low reset
//   start_i, mode_i, pattern_i, base_addr_i, num_words_i : test setup, sampled on start
//   busy_o, done_o        : status (done_o is a one-cycle pulse)
//   err_cnt_o             : saturating error count
//   first_err_addr_o      : address of first error (valid when err_cnt_o != 0)
//   req_o/add_o/wen_o/wdata_o/be_o, gnt_i : TCDM request channel
//   r_valid_i/r_rdata_i/r_opc_i           : TCDM in-order response channel
module l2_tcdm_bist_master
    import l2_tcdm_bist_pkg::*;
#(
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned ADDR_STRIDE     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ERR_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [1:0]       pattern_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] num_words_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [31:0]      first_err_addr_o,
    output logic             req_o,
    output logic [31:0]      add_o,
    output logic             wen_o,
    output logic [31:0]      wdata_o,
    output logic [3:0]       be_o,
    input  logic             gnt_i,
    input  logic             r_valid_i,
    input  logic [31:0]      r_rdata_i,
    input  logic             r_opc_i
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    pattern_e           pat_q, pat_d;
    logic [31:0]        base_q, base_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   ridx_q, ridx_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [31:0]        ferr_q, ferr_d;

    logic        issue_st, accept, last_issue;
    logic        rsp_active, stray, rsp_ok, rsp_is_read, rsp_err;
    logic [31:0] rsp_addr;

    assign issue_st   = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign req_o      = issue_st && (out_q < OUT_W'(MAX_OUTSTANDING));
    assign accept     = req_o && gnt_i;
    assign last_issue = (idx_q == num_q - CNT_W'(1));

    // Request fields derive from registered state only, so they hold while stalled.
    assign add_o   = base_q + 32'(idx_q) * 32'(ADDR_STRIDE);
    assign wen_o   = (state_q != ST_WRITE);
    assign wdata_o = pattern_data(pat_q, add_o);
    assign be_o    = BE_ALL;

    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = ferr_q;

    // Write responses are fully drained before reads start, so the state alone
    // tells whether a response belongs to a read.
    assign rsp_addr    = base_q + 32'(ridx_q) * 32'(ADDR_STRIDE);
    assign rsp_active  = r_valid_i && (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign stray       = rsp_active && (out_q == '0);
    assign rsp_ok      = rsp_active && !stray;
    assign rsp_is_read = (state_q == ST_READ) || (state_q == ST_RD_DRAIN);
    assign rsp_err     = stray || r_opc_i ||
                         (rsp_is_read && (r_rdata_i != pattern_data(pat_q, rsp_addr)));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        ridx_d  = ridx_q;
        out_d   = out_q;
        err_d   = err_q;
        ferr_d  = ferr_q;

        if (accept && !rsp_ok) begin
            out_d = out_q + OUT_W'(1);
        end else if (!accept && rsp_ok) begin
            out_d = out_q - OUT_W'(1);
        end

        if (rsp_ok) begin
            ridx_d = ridx_q + CNT_W'(1);
        end

        if (rsp_active && rsp_err) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                ferr_d = rsp_addr;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d = mode_e'(mode_i);
                    pat_d  = pattern_e'(pattern_i);
                    base_d = base_addr_i;
                    num_d  = num_words_i;
                    idx_d  = '0;
                    ridx_d = '0;
                    err_d  = '0;
                    ferr_d = '0;
                    if (num_words_i == '0) begin
                        state_d = ST_DONE;
                    end else if (mode_e'(mode_i) == MODE_CHK_ONLY) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    if (last_issue) begin
                        idx_d   = '0;
                        state_d = ST_WR_DRAIN;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            // Drains look at the next outstanding count so done follows the
            // final response by one cycle.
            ST_WR_DRAIN: begin
                if (out_d == '0) begin
                    ridx_d  = '0;
                    state_d = (mode_q == MODE_WR_ONLY) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (accept) begin
                    if (last_issue) begin
                        idx_d   = '0;
                        state_d = ST_RD_DRAIN;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            ST_RD_DRAIN: begin
                if (out_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WR_CHK;
            pat_q   <= PAT_ZERO;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            ridx_q  <= '0;
            out_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            ridx_q  <= ridx_d;
            out_q   <= out_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_l2_tcdm_bist_master.sv
module tb_l2_tcdm_bist_master;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [1:0]  pattern_i = '0;
    logic [31:0] base_addr_i = '0;
    logic [19:0] num_words_i = '0;
    logic        busy_o, done_o;
    logic [15:0] err_cnt_o;
    logic [31:0] first_err_addr_o;
    logic        req_o, wen_o;
    logic [31:0] add_o, wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i;
    logic        r_valid_i = 1'b0;
    logic [31:0] r_rdata_i = '0;
    logic        r_opc_i = 1'b0;

    l2_tcdm_bist_master #(
        .CNT_W(20), .ADDR_STRIDE(4), .MAX_OUTSTANDING(MAXO), .ERR_W(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .pattern_i(pattern_i), .base_addr_i(base_addr_i), .num_words_i(num_words_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o), .req_o(req_o), .add_o(add_o),
        .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o), .gnt_i(gnt_i),
        .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; } req_t;
    typedef struct { int due; logic [31:0] rdata; logic opc; } rsp_t;
    typedef struct { logic [15:0] err; logic [31:0] first; bit chk_lat; } res_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    res_t res_q[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;
    int tb_out = 0;
    int last_rv_cyc = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int stall_left = 0;
    bit stall_arm = 0;
    logic [31:0] stall_addr = '0;
    bit opc_arm = 0;
    bit prev_acc = 0;
    logic gnt_en = 1'b1;

    always_comb gnt_i = req_o && gnt_en;

    function automatic logic [31:0] pat(input logic [1:0] p, input logic [31:0] a);
        case (p)
            2'd0: return 32'h0000_0000;
            2'd1: return 32'hFFFF_FFFF;
            2'd2: return a;
            default: return ~a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder, request monitor and completion monitor, all sampled mid-cycle.
    always @(negedge clk_i) begin
        req_t e;
        rsp_t r;
        res_t x;
        bit acc;
        cyc++;
        if (prev_acc) tb_out++;
        if (r_valid_i) tb_out--;
        if (busy_o) busy_cyc++;

        r_valid_i = 1'b0;
        r_opc_i   = 1'b0;
        r_rdata_i = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            r_valid_i = 1'b1;
            r_rdata_i = r.rdata;
            r_opc_i   = r.opc;
            last_rv_cyc = cyc;
        end

        if (stall_left > 0) stall_left--;
        if (stall_arm && req_o && !wen_o && add_o == stall_addr) begin
            stall_left = 5;
            stall_arm  = 0;
        end
        gnt_en = (stall_left == 0);
        acc = req_o && gnt_en;

        if (req_o && !gnt_en && req_q.size() > 0) begin
            chk("hold_add", add_o, req_q[0].addr);
            chk("hold_wdata", wdata_o, req_q[0].wdata);
        end
        if (busy_o && tb_out >= MAXO) chk("req_sat", 32'(req_o), 32'd0);

        if (acc) begin
            chk("outstanding_lim", 32'(tb_out < MAXO), 32'd1);
            if (req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got add=0x%08h wen=%0b expected none", add_o, wen_o);
            end else begin
                e = req_q.pop_front();
                chk("req_add", add_o, e.addr);
                chk("req_wen", 32'(wen_o), 32'(e.wen));
                chk("req_be", 32'(be_o), 32'hF);
                if (!e.wen) chk("req_wdata", wdata_o, e.wdata);
            end
            r.due = cyc + lat;
            r.opc = 1'b0;
            r.rdata = '0;
            if (!wen_o) begin
                mem[add_o] = wdata_o;
                if (opc_arm) begin
                    r.opc = 1'b1;
                    opc_arm = 0;
                end
            end else begin
                r.rdata = mem.exists(add_o) ? mem[add_o] : 32'hDEAD_BEEF;
            end
            rsp_q.push_back(r);
        end
        prev_acc = acc;

        if (done_o) begin
            done_cnt++;
            if (res_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done_o=1 expected 0");
            end else begin
                x = res_q.pop_front();
                chk("err_cnt", 32'(err_cnt_o), 32'(x.err));
                if (x.err != 0) chk("first_err", first_err_addr_o, x.first);
                if (x.chk_lat) chk("done_lat", 32'(cyc), 32'(last_rv_cyc + 1));
            end
        end
    end

    task automatic push_reqs(input logic [1:0] mode, input logic [1:0] p,
                             input logic [31:0] base, input int num);
        req_t e;
        if (mode != 2'd2)
            for (int i = 0; i < num; i++) begin
                e.addr = base + 32'(i * 4); e.wen = 1'b0; e.wdata = pat(p, e.addr);
                req_q.push_back(e);
            end
        if (mode != 2'd1)
            for (int i = 0; i < num; i++) begin
                e.addr = base + 32'(i * 4); e.wen = 1'b1; e.wdata = '0;
                req_q.push_back(e);
            end
    endtask

    task automatic run(input logic [1:0] mode, input logic [1:0] p, input logic [31:0] base,
                       input int num, input logic [15:0] exp_err, input logic [31:0] exp_first);
        int d0;
        res_t x;
        push_reqs(mode, p, base, num);
        x.err = exp_err; x.first = exp_first; x.chk_lat = (num != 0);
        res_q.push_back(x);
        @(negedge clk_i);
        mode_i = mode; pattern_i = p; base_addr_i = base; num_words_i = 20'(num);
        start_i = 1'b1;
        busy_cyc = 0;
        d0 = done_cnt;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int t = 0; t < 3000 && done_cnt == d0; t++) @(negedge clk_i);
        @(negedge clk_i);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("req_left", 32'(req_q.size()), 32'd0);
        req_q.delete();
        res_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_cnt_o), 32'd0);
        chk("rst_ferr", first_err_addr_o, 32'd0);
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_add", add_o, 32'd0);
        chk("rst_wen", 32'(wen_o), 32'd1);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_be", 32'(be_o), 32'hF);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // write+check with address pattern, single-cycle responder
        lat = 1;
        run(2'd0, 2'd2, 32'h1C01_0000, 8, 16'd0, 32'h0);

        // check only, all-ones with one corrupted word
        for (int i = 0; i < 8; i++) mem[32'h1C01_0000 + 32'(i * 4)] = 32'hFFFF_FFFF;
        mem[32'h1C01_000C] = 32'hFFFF_FFFE;
        run(2'd2, 2'd1, 32'h1C01_0000, 8, 16'd1, 32'h1C01_000C);

        // grant withheld for 5 cycles on write index 2
        stall_addr = 32'h1C01_0040 + 32'd8;
        stall_arm = 1;
        run(2'd0, 2'd3, 32'h1C01_0040, 6, 16'd0, 32'h0);
        chk("stall_used", 32'(stall_arm), 32'd0);

        // long response latency saturates the outstanding window
        lat = 4;
        run(2'd0, 2'd0, 32'h1C01_0100, 16, 16'd0, 32'h0);
        lat = 1;

        // zero-length test
        run(2'd0, 2'd2, 32'h1C01_0000, 0, 16'd0, 32'h0);
        chk("zero_busy_cycles", 32'(busy_cyc), 32'd1);

        // write only with an error response on the first write
        opc_arm = 1;
        run(2'd1, 2'd1, 32'h1C01_0200, 4, 16'd1, 32'h1C01_0200);

        // reserved mode behaves as write+check
        run(2'd3, 2'd0, 32'h1C01_0300, 2, 16'd0, 32'h0);

        // asynchronous reset during write index 5
        push_reqs(2'd0, 2'd2, 32'h1C02_0000, 10);
        @(negedge clk_i);
        mode_i = 2'd0; pattern_i = 2'd2; base_addr_i = 32'h1C02_0000; num_words_i = 20'd10;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk_i);
            if (req_o && !wen_o && add_o == 32'h1C02_0014) found = 1;
        end
        chk("rst_reached_idx5", 32'(found), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst_req", 32'(req_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        req_q.delete();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
        chk("post_rst_err", 32'(err_cnt_o), 32'd0);
        run(2'd0, 2'd2, 32'h1C02_0000, 4, 16'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
